// File: rtl/fb_pkg.sv
// Shared types for the framebuffer port-A arbiter: widths, FSM states, owner encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_BLT = 2'd2
  } fb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_BLT = 1'b1
  } fb_owner_t;

  // State in which the given requester owns port A
  function automatic fb_state_t owner_state(input fb_owner_t o);
    return (o == OWNER_CPU) ? OWN_CPU : OWN_BLT;
  endfunction

  function automatic fb_owner_t other_owner(input fb_owner_t o);
    return (o == OWNER_CPU) ? OWNER_BLT : OWNER_CPU;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of CPU/blitter request channels and framebuffer port-A signals.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/addr/we/wdata until req && gnt at an edge.
interface fb_port_arbiter_if import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              blt_req;
  logic              blt_we;
  logic [ADDR_W-1:0] blt_addr;
  logic [DATA_W-1:0] blt_wdata;
  logic              blt_gnt;
  logic [DATA_W-1:0] blt_rdata;
  logic              blt_rvalid;

  logic [ADDR_W-1:0] port_a_address;
  logic [DATA_W-1:0] port_a_din;
  logic              port_a_we;
  logic [DATA_W-1:0] port_a_dout;

  // Requesters plus the RAM read-data return
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output blt_req, blt_we, blt_addr, blt_wdata,
    output port_a_dout,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  blt_gnt, blt_rdata, blt_rvalid,
    input  port_a_address, port_a_din, port_a_we
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  blt_req, blt_we, blt_addr, blt_wdata,
    input  port_a_dout,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output blt_gnt, blt_rdata, blt_rvalid,
    output port_a_address, port_a_din, port_a_we
  );

endinterface

// File: rtl/fb_read_return.sv
// Routes port-A read data back to whichever requester issued the read.
// Latency: rvalid one cycle after the accepting edge; rdata holds until that requester's next rvalid.
// Backpressure: none; returns cannot be stalled, and reset in the return cycle suppresses the pulse.
module fb_read_return import fb_pkg::*; #(
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_acc_rd,
  input  fb_owner_t         i_owner,
  input  logic [DATA_W-1:0] i_dout,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_blt_rvalid,
  output logic [DATA_W-1:0] o_blt_rdata
);

  logic              r_rpend;
  fb_owner_t         r_rsel;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_blt_rdata;
  logic              w_cpu_rv;
  logic              w_blt_rv;

  // Pulse the selected requester; RAM data passes straight through in the valid cycle
  always_comb begin
    w_cpu_rv     = r_rpend && !reset && (r_rsel == OWNER_CPU);
    w_blt_rv     = r_rpend && !reset && (r_rsel == OWNER_BLT);
    o_cpu_rvalid = w_cpu_rv;
    o_blt_rvalid = w_blt_rv;
    o_cpu_rdata  = w_cpu_rv ? i_dout : r_cpu_rdata;
    o_blt_rdata  = w_blt_rv ? i_dout : r_blt_rdata;
  end

  // Track the in-flight read and keep the last returned word per requester
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpend     <= 1'b0;
      r_rsel      <= OWNER_CPU;
      r_cpu_rdata <= '0;
      r_blt_rdata <= '0;
    end else begin
      r_rpend <= i_acc_rd;
      if (i_acc_rd) r_rsel <= i_owner;
      if (w_cpu_rv) r_cpu_rdata <= i_dout;
      if (w_blt_rv) r_blt_rdata <= i_dout;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Round-robin owner of framebuffer port A between CPU and blitter, with bounded bursts.
// Latency: grant one cycle after req seen in IDLE; handover with no dead cycle; read data 1 cycle after accept.
// Backpressure: gnt low holds the requester; a beat is taken on every edge with req && gnt.
module fb_port_arbiter import fb_pkg::*; #(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                reset,
  fb_port_arbiter_if.slave    bus
);

  localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

  fb_state_t         r_state;
  fb_state_t         w_state_nxt;
  fb_owner_t         r_last_owner;
  fb_owner_t         w_last_owner_nxt;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [CNT_W-1:0]  w_burst_cnt_nxt;

  logic              w_owned;
  fb_owner_t         w_owner;
  logic              w_own_req;
  logic              w_own_we;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_oth_req;
  logic              w_acc_rd;

  // Select the owning requester's channel; unknown encodings behave as IDLE
  always_comb begin
    w_owned     = 1'b0;
    w_owner     = OWNER_CPU;
    w_own_req   = 1'b0;
    w_own_we    = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    w_oth_req   = 1'b0;
    case (r_state)
      OWN_CPU: begin
        w_owned     = 1'b1;
        w_owner     = OWNER_CPU;
        w_own_req   = bus.cpu_req;
        w_own_we    = bus.cpu_we;
        w_own_addr  = bus.cpu_addr;
        w_own_wdata = bus.cpu_wdata;
        w_oth_req   = bus.blt_req;
      end
      OWN_BLT: begin
        w_owned     = 1'b1;
        w_owner     = OWNER_BLT;
        w_own_req   = bus.blt_req;
        w_own_we    = bus.blt_we;
        w_own_addr  = bus.blt_addr;
        w_own_wdata = bus.blt_wdata;
        w_oth_req   = bus.cpu_req;
      end
      default: ;
    endcase
  end

  // Next owner: tie goes away from the last owner; full burst yields only if the other side waits
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_burst_cnt_nxt  = r_burst_cnt;
    if (!w_owned) begin
      w_burst_cnt_nxt = '0;
      if (bus.cpu_req && bus.blt_req) w_state_nxt = owner_state(other_owner(r_last_owner));
      else if (bus.cpu_req)           w_state_nxt = OWN_CPU;
      else if (bus.blt_req)           w_state_nxt = OWN_BLT;
      else                            w_state_nxt = IDLE;
    end else if (!w_own_req) begin
      w_last_owner_nxt = w_owner;
      w_burst_cnt_nxt  = '0;
      w_state_nxt      = w_oth_req ? owner_state(other_owner(w_owner)) : IDLE;
    end else if (r_burst_cnt == CNT_LIMIT) begin
      // This accept completes the burst; with nobody waiting the count stays pinned
      if (w_oth_req) begin
        w_last_owner_nxt = w_owner;
        w_burst_cnt_nxt  = '0;
        w_state_nxt      = owner_state(other_owner(w_owner));
      end
    end else begin
      w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
    end
  end

  // State register; last_owner resets to BLT so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= OWNER_BLT;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  // Grants decode from state; port A follows the owner combinationally, zero when idle
  always_comb begin
    bus.cpu_gnt        = (r_state == OWN_CPU);
    bus.blt_gnt        = (r_state == OWN_BLT);
    bus.port_a_address = w_own_addr;
    bus.port_a_din     = w_own_wdata;
    bus.port_a_we      = w_own_req && w_own_we;
    w_acc_rd           = w_own_req && !w_own_we;
  end

  fb_read_return #(.DATA_W(DATA_W)) u_read_return (
    .clk          (clk),
    .reset        (reset),
    .i_acc_rd     (w_acc_rd),
    .i_owner      (w_owner),
    .i_dout       (bus.port_a_dout),
    .o_cpu_rvalid (bus.cpu_rvalid),
    .o_cpu_rdata  (bus.cpu_rdata),
    .o_blt_rvalid (bus.blt_rvalid),
    .o_blt_rdata  (bus.blt_rdata)
  );

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: behavioural RAM on port A, tenure-level arbitration model, directed vectors.
// Latency: model predicts grants one cycle after the deciding edge and read returns one cycle after accept.
// Backpressure: stimulus holds each beat until it is granted.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(FB_ADDR_W), .DATA_W(FB_DATA_W)) bus ();

  fb_port_arbiter #(.ADDR_W(FB_ADDR_W), .DATA_W(FB_DATA_W), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Block RAM behind port A: one-cycle read latency, read-before-write
  logic [15:0] ram [0:32767];
  always @(posedge clk) begin
    if (bus.port_a_we) ram[bus.port_a_address] <= bus.port_a_din;
    bus.port_a_dout <= ram[bus.port_a_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: who owns the port for how many beats ----------------
  int          m_own   = 0;   // 0 none, 1 cpu, 2 blitter
  int          m_last  = 2;
  int          m_beats = 0;   // beats taken in the current tenure, unbounded
  int          m_rv    = 0;   // requester owed read data this cycle
  logic [15:0] m_rdata = '0;
  bit          m_live  = 0;
  logic [15:0] shadow [int];

  function automatic logic own_req_f();
    return (m_own == 1) ? bus.cpu_req : (m_own == 2) ? bus.blt_req : 1'b0;
  endfunction
  function automatic logic own_we_f();
    return (m_own == 1) ? bus.cpu_we : (m_own == 2) ? bus.blt_we : 1'b0;
  endfunction
  function automatic int own_addr_f();
    return (m_own == 1) ? int'(bus.cpu_addr) : (m_own == 2) ? int'(bus.blt_addr) : 0;
  endfunction
  function automatic logic [15:0] own_wdata_f();
    return (m_own == 1) ? bus.cpu_wdata : (m_own == 2) ? bus.blt_wdata : 16'h0;
  endfunction
  function automatic logic oth_req_f();
    return (m_own == 1) ? bus.blt_req : (m_own == 2) ? bus.cpu_req : 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      if (own_req_f() && own_we_f()) shadow[own_addr_f()] = own_wdata_f();
      m_own = 0; m_last = 2; m_beats = 0; m_rv = 0; m_live = 1;
    end else if (m_own != 0) begin
      m_rv = 0;
      if (own_req_f()) begin
        if (own_we_f()) shadow[own_addr_f()] = own_wdata_f();
        else begin
          m_rv    = m_own;
          m_rdata = shadow.exists(own_addr_f()) ? shadow[own_addr_f()] : 16'hxxxx;
        end
        m_beats++;
        if (m_beats >= MAXB && oth_req_f()) begin
          m_last = m_own; m_own = 3 - m_own; m_beats = 0;
        end
      end else begin
        m_last  = m_own;
        m_own   = oth_req_f() ? 3 - m_own : 0;
        m_beats = 0;
      end
    end else begin
      m_rv = 0;
      if (bus.cpu_req && bus.blt_req) m_own = 3 - m_last;
      else if (bus.cpu_req)           m_own = 1;
      else if (bus.blt_req)           m_own = 2;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("m_cpu_gnt", bus.cpu_gnt, m_own == 1);
      check("m_blt_gnt", bus.blt_gnt, m_own == 2);
      check("m_we",      bus.port_a_we, own_req_f() && own_we_f());
      check("m_addr",    bus.port_a_address, own_addr_f());
      check("m_din",     bus.port_a_din, own_wdata_f());
      check("m_cpu_rv",  bus.cpu_rvalid, (m_rv == 1) && !reset);
      check("m_blt_rv",  bus.blt_rvalid, (m_rv == 2) && !reset);
      if (m_rv == 1 && !reset) check("m_cpu_rdata", bus.cpu_rdata, m_rdata);
      if (m_rv == 2 && !reset) check("m_blt_rdata", bus.blt_rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  int   cb, bb, cnt_g, cnt_w, cnt_idle;
  logic gc [0:48];
  logic gb [0:48];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.blt_req = 0; bus.blt_we = 0; bus.blt_addr = '0; bus.blt_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    step();
    step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step();
    step();
    @(negedge clk);
    check("rst_cpu_gnt", bus.cpu_gnt, 0);
    check("rst_blt_gnt", bus.blt_gnt, 0);
    check("rst_cpu_rv",  bus.cpu_rvalid, 0);
    check("rst_blt_rv",  bus.blt_rvalid, 0);
    check("rst_cpu_rd",  bus.cpu_rdata, 0);
    check("rst_blt_rd",  bus.blt_rdata, 0);
    check("rst_we",      bus.port_a_we, 0);
    step();
    reset = 0;

    // Tie from IDLE goes to CPU; write then read-back of 0x0010
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'h0010; bus.cpu_wdata = 16'hF800;
    bus.blt_req = 1; bus.blt_we = 1; bus.blt_addr = 15'h0200; bus.blt_wdata = 16'h001F;
    @(negedge clk);
    check("t1_idle_gnt", bus.cpu_gnt, 0);
    step();
    @(negedge clk);
    check("t1_cpu_gnt", bus.cpu_gnt, 1);
    check("t1_blt_gnt", bus.blt_gnt, 0);
    check("t1_we",      bus.port_a_we, 1);
    check("t1_addr",    bus.port_a_address, 15'h0010);
    check("t1_din",     bus.port_a_din, 16'hF800);
    step();
    bus.cpu_we = 0;
    step();
    bus.cpu_req = 0;
    @(negedge clk);
    check("t2_cpu_rv",    bus.cpu_rvalid, 1);
    check("t2_cpu_rdata", bus.cpu_rdata, 16'hF800);
    check("t2_blt_rv",    bus.blt_rvalid, 0);
    step();
    @(negedge clk);
    check("t2_handover", bus.blt_gnt, 1);
    check("t2_blt_addr", bus.port_a_address, 15'h0200);
    idle_inputs();
    step();

    // Both held: 16-beat rotation with no dead cycle
    do_reset();
    cb = 0; bb = 0;
    for (int c = 0; c < 49; c++) begin
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 15'(16'h0100 + cb); bus.cpu_wdata = 16'(cb);
      bus.blt_req = 1; bus.blt_we = 1; bus.blt_addr = 15'(16'h0400 + bb); bus.blt_wdata = 16'(bb + 16'h4000);
      @(negedge clk);
      gc[c] = bus.cpu_gnt;
      gb[c] = bus.blt_gnt;
      step();
      if (gc[c]) cb++;
      if (gb[c]) bb++;
    end
    cnt_g = 0; cnt_idle = 0;
    for (int c = 1; c <= 16; c++) if (gc[c]) cnt_g++;
    check("rot_cpu_first16", cnt_g, 16);
    check("rot_blt_at17", gb[17], 1);
    check("rot_cpu_at17", gc[17], 0);
    cnt_g = 0;
    for (int c = 17; c <= 32; c++) if (gb[c]) cnt_g++;
    check("rot_blt_next16", cnt_g, 16);
    check("rot_cpu_at33", gc[33], 1);
    for (int c = 1; c <= 48; c++) if (!gc[c] && !gb[c]) cnt_idle++;
    check("rot_idle", cnt_idle, 0);
    check("rot_cpu_beats", cb, 32);
    check("rot_blt_beats", bb, 16);
    idle_inputs();
    step();

    // Blitter alone: 100 writes, never released
    do_reset();
    bb = 0; cnt_g = 0; cnt_w = 0;
    for (int c = 0; c <= 100; c++) begin
      bus.blt_req = 1; bus.blt_we = 1; bus.blt_addr = 15'(bb); bus.blt_wdata = 16'h07E0;
      @(negedge clk);
      if (c >= 1 && bus.blt_gnt) cnt_g++;
      if (bus.port_a_we) cnt_w++;
      gb[0] = bus.blt_gnt;
      step();
      if (gb[0]) bb++;
    end
    check("solo_gnt_cycles", cnt_g, 100);
    check("solo_writes", cnt_w, 100);
    check("solo_beats", bb, 100);
    idle_inputs();
    step();

    // CPU read on its 16th beat still returns while blitter holds the port
    do_reset();
    cb = 0;
    for (int c = 0; c <= 16; c++) begin
      bus.cpu_req = 1;
      bus.cpu_we = (cb == 15) ? 1'b0 : 1'b1;
      bus.cpu_addr = (cb == 15) ? 15'd50 : 15'(16'h0600 + cb);
      bus.cpu_wdata = 16'(cb);
      bus.blt_req = 1; bus.blt_we = 1; bus.blt_addr = 15'h0300; bus.blt_wdata = 16'h1234;
      @(negedge clk);
      gc[0] = bus.cpu_gnt;
      step();
      if (gc[0]) cb++;
    end
    bus.cpu_req = 0;
    @(negedge clk);
    check("last_beat_blt_gnt", bus.blt_gnt, 1);
    check("last_beat_cpu_rv",  bus.cpu_rvalid, 1);
    check("last_beat_rdata",   bus.cpu_rdata, 16'h07E0);
    idle_inputs();
    step();

    // Reset the cycle after a blitter read is accepted
    do_reset();
    bus.blt_req = 1; bus.blt_we = 0; bus.blt_addr = 15'd50;
    step();
    @(negedge clk);
    check("rr_blt_gnt", bus.blt_gnt, 1);
    step();
    reset = 1;
    bus.blt_req = 0;
    @(negedge clk);
    check("rr_blt_rv_suppr", bus.blt_rvalid, 0);
    step();
    reset = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 15'd5;
    bus.blt_req = 1; bus.blt_we = 0; bus.blt_addr = 15'd6;
    @(negedge clk);
    check("rr_cpu_gnt0", bus.cpu_gnt, 0);
    check("rr_blt_gnt0", bus.blt_gnt, 0);
    check("rr_blt_rv0",  bus.blt_rvalid, 0);
    step();
    @(negedge clk);
    check("rr_tie_cpu", bus.cpu_gnt, 1);
    check("rr_tie_blt", bus.blt_gnt, 0);
    idle_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
Shares framebuffer port A (15-bit address, 16-bit data, 1-cycle read latency block RAM) between two requesters: the CPU memory-mapped path and the blitter/fill engine. Port B stays owned by the LCD scan-out controller, so this block never touches it. Uses round-robin arbitration with bounded bursts so that neither side can starve the other during full-screen clears.

Parameters:
ADDR_W, 15, framebuffer word address width
DATA_W, 16, pixel word width
MAX_BURST, 16, maximum consecutive accepted beats per grant while the other side waits (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU requests a beat; address, write-enable and write data are valid while it is high
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  CPU owns port A; a beat is accepted on every edge where cpu_req && cpu_gnt
cpu_rdata  output  DATA_W  read data for CPU
cpu_rvalid  output  1  one-cycle pulse; cpu_rdata is valid
blt_req, blt_we, blt_addr, blt_wdata  input  1/1/ADDR_W/DATA_W  same as the CPU equivalents, for the blitter
blt_gnt, blt_rdata, blt_rvalid  output  1/DATA_W/1  same as the CPU equivalents, for the blitter
port_a_address  output  ADDR_W  to framebuffer port A
port_a_din  output  DATA_W  to framebuffer port A
port_a_we  output  1  framebuffer port A write enable
port_a_dout  input  DATA_W  framebuffer port A read data, valid 1 cycle after the address edge

Behaviour:
- States: IDLE, OWN_CPU, OWN_BLT. gnt outputs are registered and decoded from state: cpu_gnt = (state==OWN_CPU), blt_gnt = (state==OWN_BLT).
- Reset values: state IDLE; last_owner = BLT, so the CPU wins the first tie; burst_cnt 0; both gnt 0; both rvalid 0; both rdata 0; port_a_we 0.
- Port A drive is combinational from the owner. port_a_address/din = owner's addr/wdata. port_a_we = owner_req && owner_we. In IDLE: address/din hold 0 and we = 0.
- Accept: an edge where owner_req is high. Each accept increments burst_cnt, which is $clog2(MAX_BURST)+1 bits wide.
- Read return: at an accepted read, register rsel = owner and rpend = 1. On the next cycle, the selected requester's rvalid = 1 and its rdata = port_a_dout. The rdata output is registered-through: it holds its value until the next rvalid for that requester. The other requester's rvalid stays 0.
- Transitions, evaluated every edge:
  - IDLE: if exactly one req is high, go to that owner. If both are high, go to the requester other than last_owner. The grant appears 1 cycle after req is seen, with no beat in the IDLE cycle.
  - OWN_x, own req low: if the other req is high, go directly to OWN_other (no dead cycle); otherwise go to IDLE. Set last_owner = x and clear burst_cnt.
  - OWN_x, beat accepted and burst_cnt reaches MAX_BURST-1 on this accept, other req high: go to OWN_other. Set last_owner = x and clear burst_cnt.
  - OWN_x, burst_cnt at limit, other req low: keep ownership and saturate burst_cnt at MAX_BURST-1. The counter does not wrap.
- Requesters must hold addr/we/wdata stable while req is high and gnt is low. Changing them is allowed only after an accept.
- A requester may drop req at any time. A beat counts only when req && gnt are both high at the edge.
- Read latency is fixed at 1 cycle. Back-to-back reads give rvalid on consecutive cycles. Handover never drops a pending rvalid, because rsel is independent of the current state.
- Reset mid-operation: state goes to IDLE, gnt clears at the next edge, and a pending rvalid is suppressed (rpend cleared). Any write accepted on the reset edge itself is still performed by the RAM; this is documented, not prevented.
- Unknown state encoding decodes to IDLE.

Decomposition:
- Shared package fb_pkg: FB_ADDR_W=15, FB_DATA_W=16, the state enum {IDLE, OWN_CPU, OWN_BLT}, and the owner encoding (CPU=0, BLT=1).
- One sub-module, fb_read_return: captures rsel/rpend, registers port_a_dout, and generates per-requester rvalid/rdata.
- Arbitration FSM, burst counter and port mux stay in fb_port_arbiter.

Test Plan:
- After reset, both req high at cycle 0 -> cpu_gnt=1 at cycle 1, blt_gnt=0. CPU writes addr 0x0010 data 0xF800 -> port_a_we=1, address 0x0010, din 0xF800 in that cycle.
- CPU read of addr 0x0010 accepted at edge N -> cpu_rvalid=1 at cycle N+1 with cpu_rdata=0xF800, and blt_rvalid=0.
- MAX_BURST=16, CPU req held, blt_req held -> exactly 16 CPU beats, then blt_gnt=1 on the next cycle with no idle cycle. Rotation repeats every 16 beats.
- Blitter alone streams 100 writes (addr 0..99, data 0x07E0) -> blt_gnt held throughout, 100 writes, burst_cnt saturates with no forced release.
- CPU read accepted on the final beat before handover to BLT -> cpu_rvalid still fires on the next cycle while blt_gnt=1.
- reset asserted the cycle after a BLT read is accepted -> blt_rvalid stays 0, both gnt=0 next cycle, state IDLE, CPU wins the next tie.
